// File: rtl/hex_digit_entry_pkg.sv
// Shared definitions for the hex digit entry block: digit width and FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hex_digit_entry_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ENTRY  = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;
    localparam logic [1:0] ST_SUBMIT = 2'd3;

    typedef enum logic [1:0] {
        EMPTY  = ST_EMPTY,
        ENTRY  = ST_ENTRY,
        FULL   = ST_FULL,
        SUBMIT = ST_SUBMIT
    } state_t;

endpackage

// File: rtl/hex_digit_entry_if.sv
// Bundle of key inputs and display/code outputs of the hex digit entry block.
// Latency: n/a (wires only).
// Backpressure: none; key events are one-shot and outputs are levels or strobes.
interface hex_digit_entry_if #(
    parameter int DISPLAYS = 6
);
    logic [3:0]                      digit_in;
    logic                            key_enter;
    logic                            key_delete;
    logic                            key_clear;
    logic                            key_submit;
    logic [4*DISPLAYS-1:0]           hex;
    logic [DISPLAYS-1:0]             blank;
    logic [$clog2(DISPLAYS+1)-1:0]   count;
    logic                            full;
    logic [4*DISPLAYS-1:0]           code;
    logic                            code_valid;

    modport master (
        output digit_in, key_enter, key_delete, key_clear, key_submit,
        input  hex, blank, count, full, code, code_valid
    );

    modport slave (
        input  digit_in, key_enter, key_delete, key_clear, key_submit,
        output hex, blank, count, full, code, code_valid
    );
endinterface

// File: rtl/hex_digit_entry_key_edge_detect.sv
// Two-flop synchroniser plus rising-edge detect turning a raw key level into one event pulse.
// Latency: pulse is high in the cycle after the 2nd rising edge following the key rise.
// Backpressure: none; a held key produces a single pulse, never a repeat.
module key_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;
    logic primed;
    logic armed;

    // Synchronise the key, remember the previous level, and only arm once the key has been seen
    // released after reset so a key held through reset never produces an event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= key;
            sync2  <= sync1;
            prev   <= sync2;
            primed <= 1'b1;
            armed  <= armed | (primed & ~sync1 & ~sync2);
        end
    end

    assign pulse = sync2 & ~prev & armed;

endmodule

// File: rtl/hex_digit_entry.sv
// Hex code entry: shifts switch digits into a display register, supports delete/clear/submit.
// Latency: outputs change on the 3rd rising clock edge after a raw key rises.
// Backpressure: none; events outside their legal states are silently dropped.
module hex_digit_entry
    import hex_digit_entry_pkg::*;
#(
    parameter int DISPLAYS = 6,
    parameter int HEX_MSB  = (4*DISPLAYS)-1
) (
    input  logic          clock,
    input  logic          reset,
    hex_digit_entry_if.slave bus
);

    localparam int CNT_W = $clog2(DISPLAYS+1);

    logic                ev_enter;
    logic                ev_delete;
    logic                ev_clear;
    logic                ev_submit;
    state_t              state;
    logic [HEX_MSB:0]    hex_q;
    logic [HEX_MSB:0]    code_q;
    logic [CNT_W-1:0]    count_q;
    logic                code_valid_q;
    logic [DISPLAYS-1:0] blank_c;

    key_edge_detect u_enter  (.clock(clock), .reset(reset), .key(bus.key_enter),  .pulse(ev_enter));
    key_edge_detect u_delete (.clock(clock), .reset(reset), .key(bus.key_delete), .pulse(ev_delete));
    key_edge_detect u_clear  (.clock(clock), .reset(reset), .key(bus.key_clear),  .pulse(ev_clear));
    key_edge_detect u_submit (.clock(clock), .reset(reset), .key(bus.key_submit), .pulse(ev_submit));

    // Entry FSM; one event per cycle with priority clear > submit > delete > enter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= EMPTY;
            hex_q        <= '0;
            count_q      <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            case (state)
                SUBMIT: begin
                    hex_q   <= '0;
                    count_q <= '0;
                    state   <= EMPTY;
                end
                default: begin
                    if (ev_clear) begin
                        hex_q   <= '0;
                        count_q <= '0;
                        state   <= EMPTY;
                    end else if (ev_submit) begin
                        if (state == FULL) begin
                            code_q       <= hex_q;
                            code_valid_q <= 1'b1;
                            state        <= SUBMIT;
                        end
                    end else if (ev_delete) begin
                        if (state != EMPTY) begin
                            hex_q   <= hex_q >> DIGIT_W;
                            count_q <= count_q - CNT_W'(1);
                            state   <= (count_q == CNT_W'(1)) ? EMPTY : ENTRY;
                        end
                    end else if (ev_enter) begin
                        if (state != FULL) begin
                            hex_q   <= {hex_q[HEX_MSB-DIGIT_W:0], bus.digit_in};
                            count_q <= count_q + CNT_W'(1);
                            state   <= (count_q == CNT_W'(DISPLAYS-1)) ? FULL : ENTRY;
                        end
                    end
                end
            endcase
        end
    end

    // Blank every digit position at or above the current fill level.
    always_comb begin
        blank_c = '0;
        for (int i = 0; i < DISPLAYS; i++) begin
            blank_c[i] = (i >= int'(count_q));
        end
    end

    assign bus.hex        = hex_q;
    assign bus.count      = count_q;
    assign bus.full       = (count_q == CNT_W'(DISPLAYS));
    assign bus.blank      = blank_c;
    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;

endmodule

// File: doc/hex_digit_entry.md
HEX_DIGIT_ENTRY -- requirements
Module: hex_digit_entry

Interface
REQ-001 Parameter DISPLAYS, default 6; number of hex digits entered and held.
REQ-002 Parameter HEX_MSB, default (4*DISPLAYS)-1; MSB of the digit bus.
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 digit_in  input  4  hex digit from the slide switches, sampled on an enter event.
REQ-006 key_enter  input  1  raw push-button level, active-high, asynchronous to clock.
REQ-007 key_delete  input  1  raw push-button level, active-high; removes the last digit.
REQ-008 key_clear  input  1  raw push-button level, active-high; empties the entry.
REQ-009 key_submit  input  1  raw push-button level, active-high; submits the code.
REQ-010 hex  output  HEX_MSB+1  entered digits, digit 0 in [3:0] most recent; feeds the seven-segment encoder.
REQ-011 blank  output  DISPLAYS  bit i high when digit i is unfilled, for display blanking.
REQ-012 count  output  $clog2(DISPLAYS+1)  digits currently held.
REQ-013 full  output  1  high while count == DISPLAYS.
REQ-014 code  output  HEX_MSB+1  code captured at submit.
REQ-015 code_valid  output  1  one-cycle strobe qualifying code.

Function
REQ-016 Each key input SHALL pass a 2-flop synchroniser then rising-edge detect; one press yields exactly one event pulse regardless of hold length.
REQ-017 An event SHALL change outputs on the 3rd rising clock edge after the raw key input rises (fixed latency).
REQ-018 States SHALL be EMPTY, ENTRY, FULL, SUBMIT.
REQ-019 EMPTY: enter -> shift digit_in into digit 0, count=1, go ENTRY; delete and submit ignored.
REQ-020 ENTRY: enter -> hex shifts left 4 bits, digit_in into [3:0], count+1; go FULL when count reaches DISPLAYS.
REQ-021 ENTRY/FULL: delete -> hex shifts right 4 bits, zero-filled at top, count-1; go EMPTY at count 0, ENTRY if leaving FULL.
REQ-022 FULL: enter ignored, hex unchanged, no wrap or overwrite.
REQ-023 FULL: submit -> code = hex, go SUBMIT; submit in EMPTY/ENTRY ignored.
REQ-024 SUBMIT: code_valid high exactly one cycle; next cycle hex=0, count=0, go EMPTY; keys arriving in SUBMIT ignored.
REQ-025 Clear in any state except SUBMIT -> hex=0, count=0, go EMPTY next cycle.
REQ-026 Simultaneous events in one cycle SHALL resolve by priority clear > submit > delete > enter; lower-priority events dropped.
REQ-027 blank[i] = (i >= count), combinational from count.
REQ-028 code SHALL hold its value until the next submit.

Reset
REQ-029 reset low SHALL immediately force state EMPTY, hex=0, count=0, code=0, code_valid=0, full=0, blank all ones, synchroniser and edge flops 0.
REQ-030 Reset asserted mid-entry SHALL discard digits; no event generated on deassertion even with a key held.

Structure
REQ-031 State encoding localparams and the digit width constant (4) SHALL live in the shared lock package.
REQ-032 Synchroniser plus edge detect SHALL be one sub-module, key_edge_detect, instanced once per key.

Verification
REQ-033 DISPLAYS=6; enter digits 1,2,3,4,5,6 -> hex=24'h123456, count=6, full=1, blank=6'b000000.
REQ-034 Full at 24'h123456, enter with digit_in=7 -> hex unchanged, count stays 6.
REQ-035 hex=24'h000123 count=3, delete -> hex=24'h000012, count=2, blank=6'b111100; two more deletes -> EMPTY, blank=6'b111111.
REQ-036 Full 24'hABCDEF, submit -> code=24'hABCDEF, code_valid high one cycle, following cycle hex=0 and count=0.
REQ-037 key_clear and key_enter rise on the same clock -> hex=0, count=0, no digit entered.
REQ-038 Key held 1000 cycles -> exactly one digit entered; reset pulsed mid-entry with key held -> all outputs 0, no entry after release of reset.
